// File: rtl/park_ctrl_multi.sv
// rtl/park_ctrl_multi.sv - multi-slot parking gate controller with occupancy, password lockout and departures
//
// Purpose:
//   Drives an entrance gate from its sensors and a two-digit keypad.
//   A car is admitted only when the lot has room and the password is entered
//   correctly within a timed window. Repeated wrong entries trigger a timed
//   lockout. The controller counts the cars in the lot, and departures are
//   reported by car_leave.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   sensor_entrance  in   car present at the entrance
//   sensor_exit      in   car has passed the gate
//   password_1/2     in   keypad digits, qualified by pw_valid
//   pw_valid         in   one-cycle strobe, both digits valid
//   car_leave        in   one-cycle pulse, a parked car has left the lot
//   GREEN_LED        out  green gate lamp (registered)
//   RED_LED          out  red gate lamp (registered)
//   HEX_1, HEX_2     out  active-low 7-segment patterns (registered)
//   occupancy        out  number of cars in the lot
//   full             out  occupancy == CAPACITY

module park_ctrl_multi #(
   parameter int                       CAPACITY    = 8,
   parameter int                       PW_WIDTH    = 2,
   parameter logic [PW_WIDTH-1:0]      PASSWORD_1  = 2'b01,
   parameter logic [PW_WIDTH-1:0]      PASSWORD_2  = 2'b10,
   parameter int                       WAIT_CYCLES = 16,
   parameter int                       MAX_TRIES   = 3,
   parameter int                       LOCK_CYCLES = 32
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                sensor_entrance,
   input  logic                                sensor_exit,
   input  logic [PW_WIDTH-1:0]                 password_1,
   input  logic [PW_WIDTH-1:0]                 password_2,
   input  logic                                pw_valid,
   input  logic                                car_leave,
   output logic                                GREEN_LED,
   output logic                                RED_LED,
   output logic [6:0]                          HEX_1,
   output logic [6:0]                          HEX_2,
   output logic [$clog2(CAPACITY+1)-1:0]       occupancy,
   output logic                                full
);

   localparam int OCC_W  = $clog2(CAPACITY + 1);
   localparam int WAIT_W = $clog2(WAIT_CYCLES);
   localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);

   // Segment patterns, active low, bit order gfedcba
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_N   = 7'b0101011;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_P   = 7'b0001100;
   localparam logic [6:0] SEG_F   = 7'b0001110;
   localparam logic [6:0] SEG_L   = 7'b1000111;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      WAIT_PASSWORD = 3'd1,
      WRONG_PASS    = 3'd2,
      RIGHT_PASS    = 3'd3,
      STOP          = 3'd4,
      FULL          = 3'd5,
      LOCKOUT       = 3'd6
   } state_t;

   state_t             current_state;
   state_t             next_state;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [LOCK_W-1:0]  lock_cnt;
   logic [TRY_W-1:0]   tries;
   logic               match;
   logic               wait_done;
   logic               lock_done;
   logic               tries_inc;
   logic               tries_clr;
   logic               occ_inc;

   assign match     = pw_valid && (password_1 == PASSWORD_1) && (password_2 == PASSWORD_2);
   assign wait_done = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
   assign lock_done = (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
   assign full      = (occupancy == OCC_W'(CAPACITY));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         current_state <= IDLE;
      end else begin
         current_state <= next_state;
      end
   end

   // Next-state logic and the side-effect strobes for tries and occupancy
   always_comb begin
      next_state = current_state;
      tries_inc  = 1'b0;
      tries_clr  = 1'b0;
      occ_inc    = 1'b0;
      case (current_state)
         IDLE: begin
            if (sensor_entrance) begin
               next_state = full ? FULL : WAIT_PASSWORD;
            end
         end
         FULL: begin
            if (!sensor_entrance) begin
               next_state = IDLE;
            end
         end
         WAIT_PASSWORD: begin
            // A strobe in the last window cycle still counts: pw_valid wins over timeout
            if (match) begin
               next_state = RIGHT_PASS;
            end else if (pw_valid) begin
               next_state = WRONG_PASS;
               tries_inc  = 1'b1;
            end else if (wait_done) begin
               next_state = IDLE;
               tries_clr  = 1'b1;
            end
         end
         WRONG_PASS: begin
            // tries already holds the count that includes this wrong entry
            if (tries == TRY_W'(MAX_TRIES)) begin
               next_state = LOCKOUT;
            end else begin
               next_state = WAIT_PASSWORD;
            end
         end
         RIGHT_PASS: begin
            if (sensor_entrance && sensor_exit) begin
               next_state = STOP;
            end else if (sensor_exit) begin
               next_state = IDLE;
               occ_inc    = 1'b1;
               tries_clr  = 1'b1;
            end
         end
         STOP: begin
            if (match) begin
               next_state = RIGHT_PASS;
            end
         end
         LOCKOUT: begin
            if (lock_done) begin
               next_state = IDLE;
               tries_clr  = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Window counters: zero whenever outside their state, so each visit starts at 0
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         lock_cnt <= '0;
      end else begin
         wait_cnt <= (current_state == WAIT_PASSWORD) ? wait_cnt + WAIT_W'(1) : '0;
         lock_cnt <= (current_state == LOCKOUT)       ? lock_cnt + LOCK_W'(1) : '0;
      end
   end

   // Wrong-entry counter
   always_ff @(posedge clk) begin
      if (reset) begin
         tries <= '0;
      end else if (tries_clr) begin
         tries <= '0;
      end else if (tries_inc && (tries != TRY_W'(MAX_TRIES))) begin
         tries <= tries + TRY_W'(1);
      end
   end

   // Occupancy: an arrival and a departure in the same cycle cancel out
   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy <= '0;
      end else if (occ_inc && car_leave) begin
         occupancy <= occupancy;
      end else if (occ_inc) begin
         if (!full) begin
            occupancy <= occupancy + OCC_W'(1);
         end
      end else if (car_leave) begin
         if (occupancy != '0) begin
            occupancy <= occupancy - OCC_W'(1);
         end
      end
   end

   // Registered lamp and display decode, one cycle behind current_state
   always_ff @(posedge clk) begin
      if (reset) begin
         GREEN_LED <= 1'b0;
         RED_LED   <= 1'b0;
         HEX_1     <= SEG_OFF;
         HEX_2     <= SEG_OFF;
      end else begin
         case (current_state)
            WAIT_PASSWORD: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= 1'b1;
               HEX_1     <= SEG_E;
               HEX_2     <= SEG_N;
            end
            WRONG_PASS: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= ~RED_LED;
               HEX_1     <= SEG_E;
               HEX_2     <= SEG_E;
            end
            RIGHT_PASS: begin
               GREEN_LED <= ~GREEN_LED;
               RED_LED   <= 1'b0;
               HEX_1     <= SEG_6;
               HEX_2     <= SEG_0;
            end
            STOP: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= ~RED_LED;
               HEX_1     <= SEG_5;
               HEX_2     <= SEG_P;
            end
            FULL: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= 1'b1;
               HEX_1     <= SEG_F;
               HEX_2     <= SEG_L;
            end
            LOCKOUT: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= ~RED_LED;
               HEX_1     <= SEG_L;
               HEX_2     <= SEG_0;
            end
            default: begin
               GREEN_LED <= 1'b0;
               RED_LED   <= 1'b0;
               HEX_1     <= SEG_OFF;
               HEX_2     <= SEG_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_park_ctrl_multi.sv
// tb/tb_park_ctrl_multi.sv - scoreboard testbench for park_ctrl_multi

module tb_park_ctrl_multi;

   localparam int K_HEX  = 0;
   localparam int K_LED  = 1;
   localparam int K_OCC  = 2;
   localparam int K_FULL = 3;

   localparam logic [13:0] H_OFF = {7'b1111111, 7'b1111111};
   localparam logic [13:0] H_EN  = {7'b0000110, 7'b0101011};
   localparam logic [13:0] H_EE  = {7'b0000110, 7'b0000110};
   localparam logic [13:0] H_60  = {7'b0000010, 7'b1000000};
   localparam logic [13:0] H_5P  = {7'b0010010, 7'b0001100};
   localparam logic [13:0] H_FL  = {7'b0001110, 7'b1000111};
   localparam logic [13:0] H_LO  = {7'b1000111, 7'b1000000};

   logic       clk = 1'b0;
   logic       reset;
   logic       sensor_entrance;
   logic       sensor_exit;
   logic [1:0] password_1;
   logic [1:0] password_2;
   logic       pw_valid;
   logic       car_leave;
   logic       GREEN_LED;
   logic       RED_LED;
   logic [6:0] HEX_1;
   logic [6:0] HEX_2;
   logic [3:0] occupancy;
   logic       full;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   model_occ = 0;

   always #5 clk = ~clk;

   park_ctrl_multi dut (
      .clk             (clk),
      .reset           (reset),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .password_1      (password_1),
      .password_2      (password_2),
      .pw_valid        (pw_valid),
      .car_leave       (car_leave),
      .GREEN_LED       (GREEN_LED),
      .RED_LED         (RED_LED),
      .HEX_1           (HEX_1),
      .HEX_2           (HEX_2),
      .occupancy       (occupancy),
      .full            (full)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_HEX:   return {18'b0, HEX_1, HEX_2};
         K_LED:   return {30'b0, GREEN_LED, RED_LED};
         K_OCC:   return {28'b0, occupancy};
         default: return {31'b0, full};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.val  = v;
      sb.push_back(e);
   endtask

   // One clock edge; everything expected for this edge is compared 1 time unit later
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, observe(e.kind), e.val);
      end
   endtask

   task automatic drive_pw(input logic [1:0] a, input logic [1:0] b);
      password_1 = a;
      password_2 = b;
      pw_valid   = 1'b1;
   endtask

   task automatic park(input bit leave_too);
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      drive_pw(2'b01, 2'b10);
      tick();
      pw_valid    = 1'b0;
      sensor_exit = 1'b1;
      car_leave   = leave_too;
      if (!leave_too && model_occ < 8) model_occ++;
      expect_val("park_occ", K_OCC, model_occ);
      tick();
      sensor_exit = 1'b0;
      car_leave   = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sensor_entrance = 1'b0; sensor_exit = 1'b0;
      password_1 = 2'b00; password_2 = 2'b00; pw_valid = 1'b0; car_leave = 1'b0;

      // Reset state
      expect_val("rst_hex", K_HEX, H_OFF);
      expect_val("rst_led", K_LED, 2'b00);
      expect_val("rst_occ", K_OCC, 0);
      expect_val("rst_full", K_FULL, 0);
      tick();
      reset = 1'b0;

      // Normal admission, match at wait-cycle 3
      sensor_entrance = 1'b1;
      expect_val("s1_idle_out", K_HEX, H_OFF);
      tick();
      sensor_entrance = 1'b0;
      expect_val("s1_en", K_HEX, H_EN);
      expect_val("s1_red", K_LED, 2'b01);
      tick();
      tick();
      tick();
      drive_pw(2'b01, 2'b10);
      tick();
      pw_valid = 1'b0;
      expect_val("s1_60", K_HEX, H_60);
      expect_val("s1_green1", K_LED, 2'b10);
      tick();
      expect_val("s1_green0", K_LED, 2'b00);
      tick();
      sensor_exit = 1'b1;
      model_occ = 1;
      expect_val("s1_occ", K_OCC, model_occ);
      expect_val("s1_green2", K_LED, 2'b10);
      tick();
      sensor_exit = 1'b0;
      expect_val("s1_off", K_HEX, H_OFF);
      expect_val("s1_off_led", K_LED, 2'b00);
      tick();

      // Timeout: WAIT_PASSWORD held exactly 16 cycles
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      repeat (14) tick();
      expect_val("s2_en_t15", K_HEX, H_EN);
      tick();
      expect_val("s2_en_t16", K_HEX, H_EN);
      tick();
      expect_val("s2_off_t17", K_HEX, H_OFF);
      expect_val("s2_off_led", K_LED, 2'b00);
      tick();

      // Three wrong entries lead to a 32-cycle lockout
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      drive_pw(2'b11, 2'b10);
      tick();
      pw_valid = 1'b0;
      expect_val("s3_ee1", K_HEX, H_EE);
      expect_val("s3_wrong_red", K_LED, 2'b00);
      tick();
      drive_pw(2'b11, 2'b10);
      tick();
      pw_valid = 1'b0;
      tick();
      drive_pw(2'b11, 2'b10);
      tick();
      pw_valid = 1'b0;
      expect_val("s3_ee3", K_HEX, H_EE);
      tick();
      expect_val("s3_lo_first", K_HEX, H_LO);
      expect_val("s3_lo_red", K_LED, 2'b01);
      tick();
      for (int i = 0; i < 30; i++) begin
         if (i == 10) drive_pw(2'b01, 2'b10);
         else pw_valid = 1'b0;
         tick();
      end
      pw_valid = 1'b0;
      expect_val("s3_lo_last", K_HEX, H_LO);
      tick();
      expect_val("s3_off", K_HEX, H_OFF);
      tick();

      // Fourth entry accepted; one wrong entry no longer locks out
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      drive_pw(2'b11, 2'b10);
      expect_val("s4_accept", K_HEX, H_EN);
      tick();
      pw_valid = 1'b0;
      expect_val("s4_ee", K_HEX, H_EE);
      tick();
      expect_val("s4_no_lock", K_HEX, H_EN);
      tick();

      // Tailgate into STOP and back out with the right password
      drive_pw(2'b01, 2'b10);
      tick();
      pw_valid = 1'b0;
      expect_val("s5_right", K_LED, 2'b10);
      tick();
      sensor_entrance = 1'b1;
      sensor_exit     = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      sensor_exit     = 1'b0;
      expect_val("s5_stop", K_HEX, H_5P);
      expect_val("s5_red1", K_LED, 2'b01);
      tick();
      drive_pw(2'b11, 2'b10);
      expect_val("s5_red0", K_LED, 2'b00);
      tick();
      pw_valid = 1'b0;
      expect_val("s5_stay", K_HEX, H_5P);
      expect_val("s5_red1b", K_LED, 2'b01);
      tick();
      drive_pw(2'b01, 2'b10);
      expect_val("s5_stay2", K_HEX, H_5P);
      tick();
      pw_valid = 1'b0;
      expect_val("s5_back", K_HEX, H_60);
      tick();
      sensor_exit = 1'b1;
      model_occ = 2;
      expect_val("s5_occ", K_OCC, model_occ);
      tick();
      sensor_exit = 1'b0;
      tick();

      // Departures down to zero, then saturation; sensor_exit in IDLE is ignored
      car_leave = 1'b1;
      expect_val("leave_1", K_OCC, 1);
      tick();
      expect_val("leave_0", K_OCC, 0);
      tick();
      expect_val("leave_at_zero", K_OCC, 0);
      tick();
      car_leave   = 1'b0;
      sensor_exit = 1'b1;
      expect_val("idle_exit_occ", K_OCC, 0);
      tick();
      sensor_exit = 1'b0;
      model_occ   = 0;

      // Fill the lot; the fifth park coincides with a departure at 4
      for (int i = 0; i < 9; i++) park(i == 4);
      expect_val("fill_full", K_FULL, 1);
      expect_val("fill_occ", K_OCC, 8);
      tick();

      // Full-lot refusal
      sensor_entrance = 1'b1;
      tick();
      expect_val("full_hex", K_HEX, H_FL);
      expect_val("full_red", K_LED, 2'b01);
      expect_val("full_flag", K_FULL, 1);
      tick();
      car_leave = 1'b1;
      model_occ = 7;
      expect_val("full_leave_occ", K_OCC, model_occ);
      expect_val("full_leave_flag", K_FULL, 0);
      tick();
      car_leave = 1'b0;
      expect_val("full_hold", K_HEX, H_FL);
      tick();
      sensor_entrance = 1'b0;
      tick();
      expect_val("full_exit", K_HEX, H_OFF);
      tick();

      // Reset while locked out
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_pw(2'b11, 2'b10);
         tick();
         pw_valid = 1'b0;
         tick();
      end
      expect_val("lock2_lo", K_HEX, H_LO);
      tick();
      reset = 1'b1;
      expect_val("rst_lock_hex", K_HEX, H_OFF);
      expect_val("rst_lock_led", K_LED, 2'b00);
      expect_val("rst_lock_occ", K_OCC, 0);
      expect_val("rst_lock_full", K_FULL, 0);
      tick();
      reset = 1'b0;
      expect_val("rst_lock_idle", K_HEX, H_OFF);
      tick();
      sensor_entrance = 1'b1;
      tick();
      sensor_entrance = 1'b0;
      expect_val("post_reset_en", K_HEX, H_EN);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
